sync_fifo_stream_reader: RTL and testbench

Read-side controller for the 8x8 synchronous FIFO (`sync_8x8_fifo`).
- Drains the FIFO through its `re`/`r_data`/`empty`/`almost_empty` port and presents words on a valid/ready stream to the downstream consumer.
- Absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, so it sustains one word per clock.
- Never reads an empty FIFO, so the FIFO's underrun condition cannot occur.
- Adds low-occupancy batching (timeout) and a flush command.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/sync_fifo_stream_reader_skid.sv | 63 ++++++
 rtl/sync_fifo_stream_reader.sv | 98 +++++++++
 tb/tb_sync_fifo_stream_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the 8x8 FIFO read-side logic.
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH      = 8;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_WAIT,
        RD_DRAIN,
        RD_FLUSH
    } rd_state_t;
endpackage

// File: rtl/sync_fifo_stream_reader_skid.sv
// Two-entry in-order output buffer absorbing the FIFO read latency.
module stream_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  clear,
    output logic [1:0]            cnt,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  valid
);
    logic [DATA_WIDTH-1:0] tail_q;
    logic [DATA_WIDTH-1:0] head_n;
    logic [DATA_WIDTH-1:0] tail_n;
    logic [1:0]            cnt_n;

    always_comb begin
        head_n = head_data;
        tail_n = tail_q;
        cnt_n  = cnt;
        if (clear) begin
            cnt_n = 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (cnt == 2'd2) begin
                        head_n = tail_q;
                        tail_n = push_data;
                    end else begin
                        head_n = push_data;
                    end
                end
                2'b01: begin
                    head_n = tail_q;
                    cnt_n  = cnt - 2'd1;
                end
                2'b10: begin
                    if (cnt == 2'd0) head_n = push_data;
                    else             tail_n = push_data;
                    cnt_n = cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_data <= '0;
            tail_q    <= '0;
            cnt       <= 2'd0;
            valid     <= 1'b0;
        end else begin
            head_data <= head_n;
            tail_q    <= tail_n;
            cnt       <= cnt_n;
            valid     <= (cnt_n != 2'd0);
        end
    end
endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Read-side controller: drains the 8x8 FIFO onto a valid/ready stream with
// almost-empty batching and a flush command.
//   state    | meaning
//   RD_IDLE  | FIFO empty, nothing buffered
//   RD_WAIT  | one word waiting, timer running before draining
//   RD_DRAIN | reading FIFO into the skid buffer, streaming out
//   RD_FLUSH | reading and discarding until FIFO empty
module sync_fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_re,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic                  busy,
    output logic [15:0]           words_sent
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    rd_state_t  state;
    rd_state_t  state_nxt;
    logic [7:0] timer;
    logic       inflight;
    logic [1:0] cnt;
    logic [2:0] occ;
    logic       pop;
    logic       push;
    logic       clear;

    assign pop = m_valid & m_ready;
    assign occ = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RD_IDLE;
            timer      <= 8'd0;
            inflight   <= 1'b0;
            busy       <= 1'b0;
            words_sent <= 16'd0;
        end else begin
            state      <= state_nxt;
            timer      <= (state == RD_WAIT) ? timer + 8'd1 : 8'd0;
            inflight   <= fifo_re;
            busy       <= (state_nxt != RD_IDLE);
            words_sent <= words_sent + {15'd0, pop};
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = RD_FLUSH;
        end else begin
            case (state)
                RD_IDLE:
                    if (!fifo_empty) state_nxt = fifo_almost_empty ? RD_WAIT : RD_DRAIN;
                RD_WAIT:
                    if (!fifo_almost_empty || timer == TMO_LAST) state_nxt = RD_DRAIN;
                RD_DRAIN:
                    // Leave on the edge that accepts the last buffered word.
                    if (fifo_empty && !inflight &&
                        (cnt == 2'd0 || (cnt == 2'd1 && pop))) state_nxt = RD_IDLE;
                RD_FLUSH:
                    if (fifo_empty && !inflight) state_nxt = RD_IDLE;
                default: state_nxt = RD_IDLE;
            endcase
        end
    end

    always_comb begin
        fifo_re = 1'b0;
        if (state == RD_DRAIN || state == RD_FLUSH)
            fifo_re = !fifo_empty && (occ < 3'd2);
        clear = flush || (state == RD_FLUSH);
        push  = inflight && !clear;
    end

    stream_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_r_data),
        .pop       (pop),
        .clear     (clear),
        .cnt       (cnt),
        .head_data (m_data),
        .valid     (m_valid)
    );
endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench for sync_fifo_stream_reader with a queue-based FIFO model and a
// scoreboard monitor comparing every accepted stream word.
module tb_sync_fifo_stream_reader;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_empty;
    logic        fifo_almost_empty;
    logic [7:0]  fifo_r_data;
    logic        fifo_re;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] words_sent;

    sync_fifo_stream_reader #(.DATA_WIDTH(8), .TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_r_data       (fifo_r_data),
        .fifo_re           (fifo_re),
        .m_valid           (m_valid),
        .m_data            (m_data),
        .m_ready           (m_ready),
        .flush             (flush),
        .busy              (busy),
        .words_sent        (words_sent)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // FIFO model: 8-deep queue, read data valid the cycle after re is sampled.
    logic [7:0] fq[$];
    logic [7:0] pend[$];
    int reads_done = 0;
    int underruns  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fq.delete();
            pend.delete();
            fifo_empty        <= 1'b1;
            fifo_almost_empty <= 1'b1;
            fifo_r_data       <= 8'h00;
        end else begin
            if (fifo_re) begin
                if (fq.size() == 0) underruns++;
                else begin
                    fifo_r_data <= fq.pop_front();
                    reads_done++;
                end
            end
            while (pend.size() > 0 && fq.size() < 8) fq.push_back(pend.pop_front());
            fifo_empty        <= (fq.size() == 0);
            fifo_almost_empty <= (fq.size() <= 1);
        end
    end

    // Scoreboard
    logic [7:0] exp_q[$];
    int   pops_done = 0;
    int   ws_model  = 0;
    int   rd_base   = 0;
    int   pop_base  = 0;
    bit   chk_occ   = 1'b0;

    task automatic put(input logic [7:0] d);
        pend.push_back(d);
        exp_q.push_back(d);
    endtask

    initial begin : monitor
        bit         prev_stall = 1'b0;
        bit         prev_flush = 1'b0;
        logic [7:0] prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                exp_q.delete();
                ws_model   = 0;
                prev_stall = 1'b0;
            end else begin
                if (chk_occ)
                    chk("held_le_2", 32'(((reads_done - rd_base) - (pops_done - pop_base)) <= 2), 32'd1);
                if (prev_stall && !prev_flush) begin
                    chk("stall_valid", 32'(m_valid), 32'd1);
                    chk("stall_data", 32'(m_data), 32'(prev_data));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) chk("spurious_word", 32'(m_data), 32'hFFFF_FFFF);
                    else chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
                    pops_done++;
                    ws_model++;
                end
                if (flush) exp_q.delete();
                prev_stall = m_valid && !m_ready;
                prev_flush = flush;
                prev_data  = m_data;
            end
        end
    end

    // mode 0: hold m_ready, 1: random, 2: pattern 1,0,0,1
    task automatic run_until_idle(input int mode, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (mode == 1) m_ready = ($urandom_range(0, 3) != 0);
            if (mode == 2) m_ready = (i % 4 == 0) || (i % 4 == 3);
            #2;
            done = !busy && !m_valid && fifo_empty && exp_q.size() == 0 && pend.size() == 0;
        end
        chk("idle_reached", 32'(done), 32'd1);
    endtask

    task automatic measure_latency(output int edges_after);
        int n = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            n++;
            #1;
            seen = m_valid;
        end
        if (!seen) chk("first_valid_timeout", 32'd0, 32'd1);
        edges_after = n - 1;
    endtask

    task automatic rebase();
        rd_base  = reads_done;
        pop_base = pops_done;
        chk_occ  = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int ws_before;
        bit hit;
        logic [7:0] drain_words [8];
        drain_words = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};

        // Reset held low
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_words_sent", 32'(words_sent), 32'd0);
        chk("rst_fifo_re", 32'(fifo_re), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        rebase();

        // Full drain: writes land at edge W, IDLE->DRAIN at W+1, read at W+2, push at W+3
        @(negedge clk);
        m_ready = 1'b1;
        foreach (drain_words[i]) put(drain_words[i]);
        measure_latency(lat);
        chk("drain_latency", 32'(lat), 32'd3);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("no_bubble", 32'(m_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        chk("drain_end_valid", 32'(m_valid), 32'd0);
        chk("drain_busy_fall", 32'(busy), 32'd0);
        run_until_idle(0, 20);
        chk("drain_words_sent", 32'(words_sent), 32'd8);

        // Backpressure
        @(negedge clk);
        for (int i = 0; i < 8; i++) put(8'(8'h30 + i * 7));
        run_until_idle(2, 80);
        chk("bp_words_sent", 32'(words_sent), 32'd16);

        // Timeout: single word sits in WAIT for TMO extra edges
        @(negedge clk);
        m_ready = 1'b1;
        put(8'hA5);
        measure_latency(lat);
        chk("timeout_latency", 32'(lat), 32'(3 + TMO));
        run_until_idle(0, 20);
        chk("timeout_words_sent", 32'(words_sent), 32'd17);

        // Flush with downstream stalled
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) put(8'($urandom));
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            #2;
            hit = m_valid;
        end
        chk("flush_pre_valid", 32'(hit), 32'd1);
        repeat (2) @(negedge clk);
        ws_before = 32'(words_sent);
        flush = 1'b1;
        chk_occ = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #2;
        chk("flush_valid_low", 32'(m_valid), 32'd0);
        run_until_idle(0, 40);
        chk("flush_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("flush_words_sent", 32'(words_sent), 32'(ws_before));
        rebase();

        // Reset mid-stream after 3 accepted words
        @(negedge clk);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) put(8'(8'hC0 + i));
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk);
            #1;
            hit = (words_sent == 16'(ws_before + 3));
        end
        chk("mid_three_sent", 32'(hit), 32'd1);
        #2;
        rst = 1'b0;
        chk_occ = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_words_sent", 32'(words_sent), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fifo_re", 32'(fifo_re), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rebase();
        @(negedge clk);
        for (int i = 0; i < 4; i++) put(8'(8'h50 + i));
        run_until_idle(0, 30);
        chk("restart_words_sent", 32'(words_sent), 32'd4);

        // Random bursts with random backpressure
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 8);
            @(negedge clk);
            for (int i = 0; i < n; i++) put(8'($urandom));
            run_until_idle(1, 120);
            chk("rand_words_sent", 32'(words_sent), 32'(16'(ws_model)));
        end

        chk("underruns", 32'(underruns), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
